// File: rtl/dma_intr_pkg.sv
// Shared types and defaults for the DMA interrupt generator and its cause queue.
// The optional acknowledge watchdog is enabled by DMA_INTR_TIMEOUT_EN (see dma_intr_gen).
package dma_intr_pkg;

  localparam int unsigned FIFO_DEPTH_DEF  = 4;
  localparam int unsigned TIMEOUT_CYC_DEF = 255;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'b00,
    CAUSE_DONE = 2'b01,
    CAUSE_ERR  = 2'b10,
    CAUSE_BOTH = 2'b11
  } cause_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_ASSERT   = 2'b01,
    ST_WAIT_REL = 2'b10
  } state_e;

  // Bit 0 is the done flag and bit 1 the error flag, so the enum values fall out directly.
  function automatic cause_e encode_cause(input logic done, input logic err);
    return cause_e'({err, done});
  endfunction

endpackage

// File: rtl/intr_cause_fifo.sv
// Circular queue of interrupt causes; DEPTH must be a power of two so the
// pointers wrap naturally. A push at full succeeds only when a pop happens too.
module intr_cause_fifo
  import dma_intr_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  cause_e                   data_i,
  input  logic                     pop_i,
  output cause_e                   head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ZERO_CNT = {(AW + 1){1'b0}};

  cause_e          r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic            w_full;
  logic            w_empty;
  logic            w_do_push;
  logic            w_do_pop;

  assign w_full    = (r_count == FULL_CNT);
  assign w_empty   = (r_count == ZERO_CNT);
  assign w_do_pop  = pop_i && !w_empty;
  // At full the write slot equals the head slot, which is read combinationally before the edge.
  assign w_do_push = push_i && (!w_full || w_do_pop);

  // Cause storage; contents are don't-care until written, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= ZERO_CNT;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign head_o  = r_mem[r_rd_ptr];
  assign full_o  = w_full;
  assign empty_o = w_empty;
  assign count_o = r_count;

endmodule

// File: rtl/dma_intr_gen.sv
// DMA interrupt generator: queues done/error causes and hands them to the CPU one
// at a time with a level interrupt. Define DMA_INTR_TIMEOUT_EN to add an ack watchdog.
module dma_intr_gen
  import dma_intr_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = FIFO_DEPTH_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          enable_i,
  input  logic                          done_i,
  input  logic                          err_i,
  input  logic                          clear_intr_i,
  input  logic                          ovf_clr_i,
  output logic                          dma_intr_o,
  output logic [1:0]                    cause_o,
  output logic [$clog2(FIFO_DEPTH):0]   pending_o,
  output logic                          overflow_o,
  output logic                          timeout_o
);

  state_e                         r_state;
  state_e                         w_state_nxt;
  cause_e                         r_cause;
  cause_e                         w_evt;
  cause_e                         w_head;
  logic                           r_intr;
  logic                           r_ovf;
  logic                           w_push;
  logic                           w_pop;
  logic                           w_full;
  logic                           w_empty;
  logic                           w_drop;
  logic                           w_wd_hit;
  logic [$clog2(FIFO_DEPTH):0]    w_count;

  assign w_evt  = encode_cause(done_i, err_i);
  assign w_push = (w_evt != CAUSE_NONE);
  assign w_drop = w_push && w_full && !w_pop;

  intr_cause_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .data_i  (w_evt),
    .pop_i   (w_pop),
    .head_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );

  // Dispatch sequencing; an ack always wins over a watchdog expiry in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable_i && !w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_ASSERT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ASSERT: begin
        if (clear_intr_i) begin
          w_state_nxt = ST_WAIT_REL;
        end else if (w_wd_hit) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_ASSERT;
        end
      end
      ST_WAIT_REL: begin
        if (!clear_intr_i) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT_REL;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, interrupt line, dispatched cause and sticky overflow.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_intr  <= 1'b0;
      r_cause <= CAUSE_NONE;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_intr  <= (w_state_nxt == ST_ASSERT);
      if (w_pop) begin
        r_cause <= w_head;
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr_i) begin
        r_ovf <= 1'b0;
      end
    end
  end

`ifdef DMA_INTR_TIMEOUT_EN
  localparam int unsigned      WD_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  logic [WD_W-1:0] r_wd;
  logic            r_timeout;

  // r_wd reads k-1 in the k-th ASSERT cycle, so the line drops after exactly TIMEOUT_CYC cycles.
  assign w_wd_hit = (r_state == ST_ASSERT) && (r_wd == WD_LAST) && !clear_intr_i;

  // Watchdog counter and sticky timeout flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wd      <= {WD_W{1'b0}};
      r_timeout <= 1'b0;
    end else begin
      if ((r_state == ST_ASSERT) && (w_state_nxt == ST_ASSERT)) begin
        r_wd <= r_wd + WD_W'(1);
      end else begin
        r_wd <= {WD_W{1'b0}};
      end
      if (w_wd_hit) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign timeout_o = r_timeout;
`else
  logic w_unused_timeout;

  assign w_unused_timeout = (TIMEOUT_CYC == 32'd0);
  assign w_wd_hit         = 1'b0;
  assign timeout_o        = 1'b0;
`endif

  assign dma_intr_o = r_intr;
  assign cause_o    = r_cause;
  assign pending_o  = w_count;
  assign overflow_o = r_ovf;

endmodule
